// File: rtl/rcounter_core_param.sv
// Min / sec / 10 ms countdown-or-countup timer with built-in tick prescaler,
// preset clamping, pause/resume, sticky done and optional auto-reload.
module rcounter_core_param #(
  parameter int TICK_DIV    = 100000,
  parameter int MIN_MAX     = 99,
  parameter int AUTO_RELOAD = 0,
  parameter int W           = 8
) (
  input  logic         clk_core,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic         dir,
  input  logic [W-1:0] min_i,
  input  logic [W-1:0] sec_i,
  input  logic [W-1:0] ms_10_i,
  output logic [W-1:0] min_o,
  output logic [W-1:0] sec_o,
  output logic [W-1:0] ms_10_o,
  output logic         time_out,
  output logic         done,
  output logic         running
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  MIN_TOP    = W'(MIN_MAX);
  localparam logic [W-1:0]  SEC_TOP    = W'(59);
  localparam logic [W-1:0]  MS_TOP     = W'(99);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  function automatic logic [W-1:0] sat(input logic [W-1:0] v, input logic [W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t        state, state_nx;
  logic [W-1:0]  min_q, sec_q, ms_q, min_nx, sec_nx, ms_nx;
  logic [W-1:0]  pre_min, pre_sec, pre_ms, pre_min_nx, pre_sec_nx, pre_ms_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          dir_q, dir_nx;
  logic          time_out_q, time_out_nx;
  logic [W-1:0]  st_min, st_sec, st_ms;
  logic [W-1:0]  term_min, term_sec, term_ms;
  logic          at_term, step_term, hit;

  // Candidate next count one 10 ms unit away, with borrow/carry between fields.
  always_comb begin
    st_min = min_q;
    st_sec = sec_q;
    st_ms  = ms_q;
    if (dir_q) begin
      if (ms_q == MS_TOP) begin
        st_ms = '0;
        if (sec_q == SEC_TOP) begin
          st_sec = '0;
          st_min = min_q + W'(1);
        end else begin
          st_sec = sec_q + W'(1);
        end
      end else begin
        st_ms = ms_q + W'(1);
      end
    end else begin
      if (ms_q == '0) begin
        st_ms = MS_TOP;
        if (sec_q == '0) begin
          st_sec = SEC_TOP;
          st_min = min_q - W'(1);
        end else begin
          st_sec = sec_q - W'(1);
        end
      end else begin
        st_ms = ms_q - W'(1);
      end
    end
  end

  assign term_min  = dir_q ? MIN_TOP : '0;
  assign term_sec  = dir_q ? SEC_TOP : '0;
  assign term_ms   = dir_q ? MS_TOP  : '0;
  assign at_term   = (min_q == term_min) && (sec_q == term_sec) && (ms_q == term_ms);
  assign step_term = (st_min == term_min) && (st_sec == term_sec) && (st_ms == term_ms);

  always_comb begin
    state_nx    = state;
    min_nx      = min_q;
    sec_nx      = sec_q;
    ms_nx       = ms_q;
    pre_min_nx  = pre_min;
    pre_sec_nx  = pre_sec;
    pre_ms_nx   = pre_ms;
    presc_nx    = presc;
    dir_nx      = dir_q;
    time_out_nx = 1'b0;
    hit         = 1'b0;
    if (load) begin
      pre_min_nx = sat(min_i, MIN_TOP);
      pre_sec_nx = sat(sec_i, SEC_TOP);
      pre_ms_nx  = sat(ms_10_i, MS_TOP);
      min_nx     = pre_min_nx;
      sec_nx     = pre_sec_nx;
      ms_nx      = pre_ms_nx;
      presc_nx   = '0;
      state_nx   = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            state_nx = RUN;
            dir_nx   = dir;
          end
        end
        RUN: begin
          // Pausing on the tick cycle keeps the prescaler at its last value,
          // so the suppressed tick fires on the first cycle after resume.
          if (!en) begin
            state_nx = PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_nx = '0;
            if (at_term) begin
              hit = 1'b1;
            end else begin
              min_nx = st_min;
              sec_nx = st_sec;
              ms_nx  = st_ms;
              hit    = step_term;
            end
          end else begin
            presc_nx = presc + PW'(1);
          end
        end
        PAUSE: begin
          if (en) state_nx = RUN;
        end
        DONE: begin
          state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
      if (hit) begin
        time_out_nx = 1'b1;
        if (AUTO_RELOAD != 0) begin
          min_nx   = pre_min;
          sec_nx   = pre_sec;
          ms_nx    = pre_ms;
          presc_nx = '0;
        end else begin
          state_nx = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      min_q      <= '0;
      sec_q      <= '0;
      ms_q       <= '0;
      pre_min    <= '0;
      pre_sec    <= '0;
      pre_ms     <= '0;
      presc      <= '0;
      dir_q      <= 1'b0;
      time_out_q <= 1'b0;
    end else begin
      state      <= state_nx;
      min_q      <= min_nx;
      sec_q      <= sec_nx;
      ms_q       <= ms_nx;
      pre_min    <= pre_min_nx;
      pre_sec    <= pre_sec_nx;
      pre_ms     <= pre_ms_nx;
      presc      <= presc_nx;
      dir_q      <= dir_nx;
      time_out_q <= time_out_nx;
    end
  end

  assign min_o    = min_q;
  assign sec_o    = sec_q;
  assign ms_10_o  = ms_q;
  assign time_out = time_out_q;
  assign done     = (state == DONE);
  assign running  = (state == RUN);

endmodule

// File: tb/tb_rcounter_core_param.sv
// Bench for rcounter_core_param: three instances with different parameters
// share one stimulus stream and are tracked by a total-count reference model.
module tb_rcounter_core_param;
  localparam int W = 8;
  localparam int OW = 3 * W + 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic rst, en, load, dir;
  logic [W-1:0] min_i, sec_i, ms_10_i;

  logic [W-1:0] a_min, a_sec, a_ms, b_min, b_sec, b_ms, c_min, c_sec, c_ms;
  logic a_to, a_done, a_run, b_to, b_done, b_run, c_to, c_done, c_run;

  rcounter_core_param #(.TICK_DIV(2), .MIN_MAX(99), .AUTO_RELOAD(0), .W(W)) u_a (
    .clk_core(clk_core), .rst(rst), .en(en), .load(load), .dir(dir),
    .min_i(min_i), .sec_i(sec_i), .ms_10_i(ms_10_i),
    .min_o(a_min), .sec_o(a_sec), .ms_10_o(a_ms),
    .time_out(a_to), .done(a_done), .running(a_run));

  rcounter_core_param #(.TICK_DIV(4), .MIN_MAX(99), .AUTO_RELOAD(0), .W(W)) u_b (
    .clk_core(clk_core), .rst(rst), .en(en), .load(load), .dir(dir),
    .min_i(min_i), .sec_i(sec_i), .ms_10_i(ms_10_i),
    .min_o(b_min), .sec_o(b_sec), .ms_10_o(b_ms),
    .time_out(b_to), .done(b_done), .running(b_run));

  rcounter_core_param #(.TICK_DIV(3), .MIN_MAX(5), .AUTO_RELOAD(1), .W(W)) u_c (
    .clk_core(clk_core), .rst(rst), .en(en), .load(load), .dir(dir),
    .min_i(min_i), .sec_i(sec_i), .ms_10_i(ms_10_i),
    .min_o(c_min), .sec_o(c_sec), .ms_10_o(c_ms),
    .time_out(c_to), .done(c_done), .running(c_run));

  typedef struct {
    int st; int t; int pm; int ps; int pms; int presc; bit dq; bit to;
  } mdl_t;

  typedef struct {
    bit en; bit load; bit dir; int mi; int si; int msi;
    int emin; int esec; int ems; bit eto; bit edone; bit erun;
  } vec_t;

  mdl_t m[3];
  int   td[3];
  int   mm[3];
  bit   ar[3];
  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = S_IDLE; r.t = 0; r.pm = 0; r.ps = 0; r.pms = 0; r.presc = 0; r.dq = 0; r.to = 0;
    return r;
  endfunction

  // Count held as one total in 10 ms units; fields are derived only for output.
  function automatic mdl_t mdl_step(mdl_t s, int tdv, int mmax, bit arl,
                                    bit e, bit ld, bit d, int mi, int si, int msi);
    mdl_t n = s;
    int term;
    bit ev = 0;
    n.to = 0;
    if (ld) begin
      n.pm = (mi > mmax) ? mmax : mi;
      n.ps = (si > 59) ? 59 : si;
      n.pms = (msi > 99) ? 99 : msi;
      n.t = n.pm * 6000 + n.ps * 100 + n.pms;
      n.presc = 0;
      n.st = S_IDLE;
      return n;
    end
    term = s.dq ? mmax * 6000 + 5999 : 0;
    case (s.st)
      S_IDLE: if (e) begin n.st = S_RUN; n.dq = d; end
      S_RUN: begin
        if (!e) n.st = S_PAUSE;
        else if (s.presc == tdv - 1) begin
          n.presc = 0;
          if (s.t == term) ev = 1;
          else begin
            n.t = s.dq ? s.t + 1 : s.t - 1;
            ev = (n.t == term);
          end
        end else n.presc = s.presc + 1;
      end
      S_PAUSE: if (e) n.st = S_RUN;
      default: ;
    endcase
    if (ev) begin
      n.to = 1;
      if (arl) begin
        n.t = n.pm * 6000 + n.ps * 100 + n.pms;
        n.presc = 0;
      end else n.st = S_DONE;
    end
    return n;
  endfunction

  function automatic logic [OW-1:0] pack(int t, bit to, bit dn, bit rn);
    return {W'(t / 6000), W'((t / 100) % 60), W'(t % 100), to, dn, rn};
  endfunction

  function automatic logic [OW-1:0] mdl_out(mdl_t s);
    return pack(s.t, s.to, s.st == S_DONE, s.st == S_RUN);
  endfunction

  function automatic logic [OW-1:0] dut_out(int i);
    case (i)
      0: return {a_min, a_sec, a_ms, a_to, a_done, a_run};
      1: return {b_min, b_sec, b_ms, b_to, b_done, b_run};
      default: return {c_min, c_sec, c_ms, c_to, c_done, c_run};
    endcase
  endfunction

  task automatic chk(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d:%0d:%0d to=%b done=%b run=%b, want %0d:%0d:%0d to=%b done=%b run=%b",
               name, $time, act[OW-1 -: W], act[2*W+2 -: W], act[W+2 -: W], act[2], act[1], act[0],
               exp[OW-1 -: W], exp[2*W+2 -: W], exp[W+2 -: W], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare every instance 1 ns later.
  task automatic cycle();
    @(posedge clk_core);
    for (int i = 0; i < 3; i++) begin
      if (!rst) m[i] = mdl_reset();
      else m[i] = mdl_step(m[i], td[i], mm[i], ar[i], en, load, dir,
                           int'(min_i), int'(sec_i), int'(ms_10_i));
    end
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("model_u%0d", i), dut_out(i), mdl_out(m[i]));
  endtask

  task automatic drive(bit e, bit ld, bit d, int mi, int si, int msi);
    en = e; load = ld; dir = d;
    min_i = W'(mi); sec_i = W'(si); ms_10_i = W'(msi);
  endtask

  task automatic addv(bit e, bit ld, bit d, int mi, int si, int msi,
                      int emin, int esec, int ems, bit eto, bit edn, bit ern);
    vec_t v;
    v.en = e; v.load = ld; v.dir = d; v.mi = mi; v.si = si; v.msi = msi;
    v.emin = emin; v.esec = esec; v.ems = ems; v.eto = eto; v.edone = edn; v.erun = ern;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    td[0] = 2; td[1] = 4; td[2] = 3;
    mm[0] = 99; mm[1] = 99; mm[2] = 5;
    ar[0] = 0; ar[1] = 0; ar[2] = 1;
    for (int i = 0; i < 3; i++) m[i] = mdl_reset();

    // Directed table for the TICK_DIV=2 instance (u_a).
    addv(0,1,0,   0, 0,  3,   0, 0, 3, 0,0,0);
    addv(1,0,0,   0, 0,  0,   0, 0, 3, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0, 0, 3, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0, 0, 2, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0, 0, 2, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0, 0, 1, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0, 0, 1, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0, 0, 0, 1,1,0);
    addv(1,0,0,   0, 0,  0,   0, 0, 0, 0,1,0);
    addv(1,0,0,   0, 0,  0,   0, 0, 0, 0,1,0);
    addv(1,1,0, 120,75,150,  99,59,99, 0,0,0);
    addv(0,1,0,   1, 0,  0,   1, 0, 0, 0,0,0);
    addv(1,0,0,   0, 0,  0,   1, 0, 0, 0,0,1);
    addv(1,0,0,   0, 0,  0,   1, 0, 0, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0,59,99, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0,59,99, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0,59,98, 0,0,1);
    addv(1,0,0,   0, 0,  0,   0,59,98, 0,0,1);
    addv(1,1,0,   0, 0,  5,   0, 0, 5, 0,0,0);
    addv(0,1,1,  99,59, 97,  99,59,97, 0,0,0);
    addv(1,0,1,   0, 0,  0,  99,59,97, 0,0,1);
    addv(1,0,1,   0, 0,  0,  99,59,97, 0,0,1);
    addv(1,0,1,   0, 0,  0,  99,59,98, 0,0,1);
    addv(1,0,1,   0, 0,  0,  99,59,98, 0,0,1);
    addv(1,0,1,   0, 0,  0,  99,59,99, 1,1,0);
    addv(1,0,1,   0, 0,  0,  99,59,99, 0,1,0);
    addv(1,0,0,   0, 0,  0,  99,59,99, 0,1,0);
    addv(0,0,0,   0, 0,  0,  99,59,99, 0,1,0);
    addv(1,0,0,   0, 0,  0,  99,59,99, 0,1,0);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #22;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_u%0d", i), dut_out(i), pack(0, 0, 0, 0));
    rst = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].load, tbl[k].dir, tbl[k].mi, tbl[k].si, tbl[k].msi);
      cycle();
      chk($sformatf("table_row%0d", k), dut_out(0),
          pack(tbl[k].emin * 6000 + tbl[k].esec * 100 + tbl[k].ems,
               tbl[k].eto, tbl[k].edone, tbl[k].erun));
    end

    // Pause with u_b's prescaler at 2, then resume; then pause on the tick cycle.
    drive(0, 1, 0, 0, 0, 10); cycle();
    drive(1, 0, 0, 0, 0, 0);  cycle();
    cycle(); cycle();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 21; k++) begin
      cycle();
      chk("pause_hold", {b_ms, b_to, b_run}, {W'(10), 1'b0, 1'b0});
    end
    drive(1, 0, 0, 0, 0, 0);
    cycle(); chk("resume_edge", {b_ms, b_to, b_run}, {W'(10), 1'b0, 1'b1});
    cycle(); chk("resume_p3",   {b_ms, b_to, b_run}, {W'(10), 1'b0, 1'b1});
    cycle(); chk("resume_tick", {b_ms, b_to, b_run}, {W'(9),  1'b0, 1'b1});
    cycle(); cycle(); cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle(); chk("pause_on_tick", {b_ms, b_run}, {W'(9), 1'b0});
    drive(1, 0, 0, 0, 0, 0);
    cycle(); chk("held_tick_resume", {b_ms, b_run}, {W'(9), 1'b1});
    cycle(); chk("held_tick_fires",  {b_ms, b_run}, {W'(8), 1'b1});

    // Auto-reload on u_c (TICK_DIV=3), then asynchronous reset mid-count.
    drive(0, 1, 0, 0, 0, 2); cycle();
    drive(1, 0, 0, 0, 0, 0); cycle();
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      chk("reload_nonzero_running", {c_run, c_ms == '0}, {1'b1, 1'b0});
      if (c_to) pulses++;
    end
    chk_int("reload_pulse_count", pulses, 5);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m[i] = mdl_reset();
      chk($sformatf("async_reset_u%0d", i), dut_out(i), pack(0, 0, 0, 0));
    end
    cycle();
    rst = 1'b1;

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int mode;
      rst = 1'b1;
      mode = int'($urandom_range(0, 3));
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 23) == 0);
      dir  = $urandom_range(0, 1) != 0;
      if (mode == 0) begin
        min_i = 0; sec_i = 0; ms_10_i = W'($urandom_range(0, 6));
      end else if (mode == 1) begin
        min_i = W'($urandom_range(4, 255)); sec_i = W'($urandom_range(58, 255));
        ms_10_i = W'($urandom_range(94, 255));
      end else begin
        min_i = W'($urandom_range(0, 255)); sec_i = W'($urandom_range(0, 255));
        ms_10_i = W'($urandom_range(0, 255));
      end
      cycle();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          m[i] = mdl_reset();
          chk($sformatf("rand_reset_u%0d", i), dut_out(i), pack(0, 0, 0, 0));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
